d_latch: RTL and testbench



---
 rtl/d_latch.sv | 48 ++++
 tb/tb_d_latch.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/d_latch.sv
// +----------------------------------------------------------------------------+
// | Module   : d_latch                                                         |
// | Brief    : Level-sensitive D latch built from a clocked hold register and  |
// |            a combinational bypass, with true and complementary outputs.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module d_latch #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] hold_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] q_int;

  always_comb begin
    hold_d = enable ? d : hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= RESET_VALUE;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Ternaries rather than if/else so an X on enable reaches q instead of
  // silently selecting the hold path in simulation.
  always_comb begin
    q_int = !rst_n ? RESET_VALUE : (enable ? d : hold_q);
  end

  assign q     = q_int;
  assign q_bar = ~q_int;

endmodule

`default_nettype wire

// File: tb/tb_d_latch.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_d_latch                                                      |
// | Brief    : Self-checking bench for d_latch, 1-bit and 8-bit instances.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_d_latch;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       d1;
  logic       q1;
  logic       qb1;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] qb8;

  // Value each latch must show when opaque: the d seen at the most recent
  // rising edge with enable high since reset, or the reset value if none.
  logic       last1;
  logic [7:0] last8;

  int n_cmp;
  int n_bad;

  d_latch #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d1),
    .enable (enable),
    .q      (q1),
    .q_bar  (qb1)
  );

  d_latch #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (d8),
    .enable (enable),
    .q      (q8),
    .q_bar  (qb8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp1();
    return !rst_n ? 1'b0 : (enable ? d1 : last1);
  endfunction

  function automatic logic [7:0] exp8();
    return !rst_n ? RV8 : (enable ? d8 : last8);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("q1_model",  {63'd0, q1},  {63'd0, exp1()});
    check("qb1_model", {63'd0, qb1}, {63'd0, ~exp1()});
    check("q8_model",  {56'd0, q8},  {56'd0, exp8()});
    check("qb8_model", {56'd0, qb8}, {56'd0, ~exp8()});
    check("inv1", {63'd0, qb1}, {63'd0, ~q1});
    check("inv8", {56'd0, qb8}, {56'd0, ~q8});
  endtask

  always @(negedge clk) check_model();

  // Advance one edge, record what the latches should have captured, then
  // move off the edge before the caller touches the inputs.
  task automatic tick();
    @(posedge clk);
    if (rst_n === 1'b1 && enable === 1'b1) begin
      last1 = d1;
      last8 = d8;
    end
    #2;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    last1 = 1'b0;
    last8 = RV8;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    assert_reset();
    d1 = 1'b1; d8 = 8'hFF; enable = 1'b1;
    #1;
    check("rst_q1",  {63'd0, q1},  64'd0);
    check("rst_qb1", {63'd0, qb1}, 64'd1);
    check("rst_q8",  {56'd0, q8},  64'hA5);
    check("rst_qb8", {56'd0, qb8}, 64'h5A);
    tick(); tick();
    check("rst2_q1", {63'd0, q1}, 64'd0);

    rst_n = 1'b1; d1 = 1'b0; d8 = 8'h00; enable = 1'b0;
    #1;
    check("rel_q1", {63'd0, q1}, 64'd0);
    check("rel_q8", {56'd0, q8}, 64'hA5);
    tick(); tick();
    check("rel2_q1",  {63'd0, q1},  64'd0);
    check("rel2_qb1", {63'd0, qb1}, 64'd1);

    // Transparent follow
    enable = 1'b1; d1 = 1'b1;
    #1;
    check("follow1_q",  {63'd0, q1},  64'd1);
    check("follow1_qb", {63'd0, qb1}, 64'd0);
    tick();
    d1 = 1'b0;
    #1;
    check("follow0_q",  {63'd0, q1},  64'd0);
    check("follow0_qb", {63'd0, qb1}, 64'd1);
    tick();

    // Hold: edge above captured d=0
    enable = 1'b0; d1 = 1'b1;
    tick(); tick(); tick();
    check("hold_q",  {63'd0, q1},  64'd0);
    check("hold_qb", {63'd0, qb1}, 64'd1);

    // Reset pulse mid-transparency
    enable = 1'b1; d1 = 1'b1;
    tick();
    check("pre_pulse_q", {63'd0, q1}, 64'd1);
    assert_reset();
    #1;
    check("pulse_q",  {63'd0, q1},  64'd0);
    check("pulse_qb", {63'd0, qb1}, 64'd1);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_pulse_q", {63'd0, q1}, 64'd1);
    tick();
    enable = 1'b0;
    #1;
    check("recapture_q", {63'd0, q1}, 64'd1);

    // Wide instance
    enable = 1'b1; d8 = 8'h3C;
    #1;
    check("wide_follow", {56'd0, q8}, 64'h3C);
    tick();
    enable = 1'b0; d8 = 8'hFF;
    #1;
    check("wide_hold_q",  {56'd0, q8},  64'h3C);
    check("wide_hold_qb", {56'd0, qb8}, 64'hC3);
    tick();

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      d1     = 1'($urandom);
      d8     = 8'($urandom);
      enable = 1'($urandom);
      if ($urandom_range(0, 19) == 0) assert_reset();
      else rst_n = 1'b1;
      #1;
      check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
